// File: rtl/aclock_ctrl_if.sv
// aclock_ctrl_if: signal bundle between the button/time front-end and the
// aclock_ctrl user-interface controller.
//   master : environment side (drives buttons, current time, alarm flag)
//   slave  : controller side (drives BCD load value, strobes, status)
// Signals:
//   btn_mode/btn_inc/btn_ok/btn_snooze : debounced button levels
//   cur_h1/cur_h0/cur_m1/cur_m0        : current time, BCD
//   alarm_in                           : Alarm from aclock
//   H_in1/H_in0/M_in1/M_in0            : BCD value presented to aclock
//   LD_time/LD_alarm/STOP_al/AL_ON     : strobes and alarm enable
//   edit/field/tgt/busy                : controller status
interface aclock_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_ok;
  logic       btn_snooze;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0;
  logic [3:0] cur_m1;
  logic [3:0] cur_m0;
  logic       alarm_in;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       STOP_al;
  logic       AL_ON;
  logic       edit;
  logic       field;
  logic       tgt;
  logic       busy;

  modport master (
    output btn_mode, btn_inc, btn_ok, btn_snooze,
    output cur_h1, cur_h0, cur_m1, cur_m0, alarm_in,
    input  H_in1, H_in0, M_in1, M_in0,
    input  LD_time, LD_alarm, STOP_al, AL_ON,
    input  edit, field, tgt, busy
  );

  modport slave (
    input  btn_mode, btn_inc, btn_ok, btn_snooze,
    input  cur_h1, cur_h0, cur_m1, cur_m0, alarm_in,
    output H_in1, H_in0, M_in1, M_in0,
    output LD_time, LD_alarm, STOP_al, AL_ON,
    output edit, field, tgt, busy
  );
endinterface

// File: rtl/aclock_ctrl.sv
// aclock_ctrl: push-button user interface for the aclock alarm-clock datapath.
// Edits time/alarm values in BCD, presents them on H_in*/M_in* with stretched
// LD_time/LD_alarm strobes, owns AL_ON, and implements snooze (alarm moved to
// now + SNOOZE_MIN) and stop (user alarm restored), both pulsing STOP_al.
// Ports:
//   clk   : system clock shared with aclock
//   reset : synchronous, active-high
//   bus   : aclock_ctrl_if.slave (buttons, current time, alarm in; load
//           value, strobes, AL_ON and status out)
module aclock_ctrl #(
  parameter int LD_HOLD    = 12,
  parameter int SNOOZE_MIN = 5,
  parameter int TIMEOUT    = 1000
) (
  input  logic         clk,
  input  logic         reset,
  aclock_ctrl_if.slave bus
);

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_HH,
    S_SET_MM,
    S_LOAD,
    S_SNOOZE,
    S_STOP
  } state_t;

  localparam int         HOLD_W   = $clog2(LD_HOLD + 1);
  localparam int         TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [4:0] SNZ_ONES = 5'(SNOOZE_MIN % 10);
  localparam logic [4:0] SNZ_TENS = 5'(SNOOZE_MIN / 10);

  // Hours 00..23 with BCD carry; minutes untouched.
  function automatic bcd_t inc_hour(input bcd_t t);
    bcd_t r;
    r = t;
    if (t.h1 == 2'd2 && t.h0 == 4'd3) begin
      r.h1 = 2'd0;
      r.h0 = 4'd0;
    end else if (t.h0 == 4'd9) begin
      r.h1 = t.h1 + 2'd1;
      r.h0 = 4'd0;
    end else begin
      r.h0 = t.h0 + 4'd1;
    end
    return r;
  endfunction

  // Minutes 00..59, wrapping without touching the hours.
  function automatic bcd_t inc_min(input bcd_t t);
    bcd_t r;
    r = t;
    if (t.m0 == 4'd9) begin
      r.m0 = 4'd0;
      r.m1 = (t.m1 == 4'd5) ? 4'd0 : t.m1 + 4'd1;
    end else begin
      r.m0 = t.m0 + 4'd1;
    end
    return r;
  endfunction

  // Digit-wise BCD add of the snooze offset; a minute overflow bumps the hour
  // through inc_hour, which also covers the 23 -> 00 wrap.
  function automatic bcd_t add_snooze(input bcd_t t);
    bcd_t       r;
    logic [4:0] s0;
    logic [4:0] s1;
    logic       c0;
    logic       c1;
    r  = t;
    s0 = {1'b0, t.m0} + SNZ_ONES;
    c0 = (s0 >= 5'd10);
    r.m0 = c0 ? 4'(s0 - 5'd10) : s0[3:0];
    s1 = {1'b0, t.m1} + SNZ_TENS + {4'b0000, c0};
    c1 = (s1 >= 5'd6);
    r.m1 = c1 ? 4'(s1 - 5'd6) : s1[3:0];
    if (c1) begin
      r = inc_hour(r);
    end
    return r;
  endfunction

  state_t              state_reg, state_next;
  logic   [3:0]        btn_q_reg;
  bcd_t                e_reg, e_next;
  bcd_t                ash_reg, ash_next;
  bcd_t                hin_reg, hin_next;
  logic                tgt_reg, tgt_next;
  logic                al_on_reg, al_on_next;
  logic   [HOLD_W-1:0] hold_reg, hold_next;
  logic   [TO_W-1:0]   to_reg, to_next;
  logic                ld_time_reg, ld_time_next;
  logic                ld_alarm_reg, ld_alarm_next;
  logic                stop_reg, stop_next;
  logic                edit_reg, edit_next;
  logic                field_reg, field_next;
  logic                busy_reg, busy_next;

  logic [3:0] btn;
  logic [3:0] press;
  logic       press_mode, press_inc, press_ok, press_snooze;
  bcd_t       cur;

  assign btn          = {bus.btn_snooze, bus.btn_ok, bus.btn_inc, bus.btn_mode};
  assign press        = btn & ~btn_q_reg;
  assign press_mode   = press[0];
  assign press_inc    = press[1];
  assign press_ok     = press[2];
  assign press_snooze = press[3];
  assign cur          = '{h1: bus.cur_h1, h0: bus.cur_h0, m1: bus.cur_m1, m0: bus.cur_m0};

  always_comb begin
    state_next = state_reg;
    e_next     = e_reg;
    ash_next   = ash_reg;
    hin_next   = hin_reg;
    tgt_next   = tgt_reg;
    al_on_next = al_on_reg;
    hold_next  = '0;
    to_next    = '0;

    case (state_reg)
      S_IDLE: begin
        if (press_ok) begin
          if (bus.alarm_in) begin
            state_next = S_STOP;
            hin_next   = ash_reg;
          end else begin
            al_on_next = ~al_on_reg;
          end
        end else if (press_snooze && bus.alarm_in) begin
          // cur is captured here, on entry; the hold never recomputes it.
          state_next = S_SNOOZE;
          hin_next   = add_snooze(cur);
        end else if (press_mode) begin
          tgt_next   = 1'b0;
          e_next     = cur;
          state_next = S_SET_HH;
        end
      end

      S_SET_HH, S_SET_MM: begin
        if (press_mode) begin
          tgt_next   = ~tgt_reg;
          e_next     = tgt_reg ? cur : ash_reg;
          state_next = S_SET_HH;
        end else if (press_ok) begin
          if (state_reg == S_SET_HH) begin
            state_next = S_SET_MM;
          end else begin
            state_next = S_LOAD;
            hin_next   = e_reg;
            if (tgt_reg) begin
              ash_next = e_reg;
            end
          end
        end else if (press_inc) begin
          e_next = (state_reg == S_SET_HH) ? inc_hour(e_reg) : inc_min(e_reg);
        end else if (press == 4'b0000) begin
          // Any press, even an ignored one, restarts the idle count.
          if (to_reg == TO_W'(TIMEOUT - 1)) begin
            state_next = S_IDLE;
          end else begin
            to_next = to_reg + TO_W'(1);
          end
        end
      end

      S_LOAD, S_SNOOZE, S_STOP: begin
        if (hold_reg == HOLD_W'(LD_HOLD - 1)) begin
          state_next = S_IDLE;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end

      default: state_next = S_IDLE;
    endcase

    // Status and strobes are decoded from the next state so that they are
    // registered and line up exactly with the state window.
    edit_next     = (state_next == S_SET_HH) || (state_next == S_SET_MM);
    field_next    = (state_next == S_SET_MM);
    busy_next     = (state_next == S_LOAD) || (state_next == S_SNOOZE) ||
                    (state_next == S_STOP);
    ld_time_next  = (state_next == S_LOAD) && !tgt_next;
    ld_alarm_next = ((state_next == S_LOAD) && tgt_next) ||
                    (state_next == S_SNOOZE) || (state_next == S_STOP);
    stop_next     = (state_next == S_SNOOZE) || (state_next == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      btn_q_reg    <= '0;
      e_reg        <= '0;
      ash_reg      <= '0;
      hin_reg      <= '0;
      tgt_reg      <= 1'b0;
      al_on_reg    <= 1'b0;
      hold_reg     <= '0;
      to_reg       <= '0;
      ld_time_reg  <= 1'b0;
      ld_alarm_reg <= 1'b0;
      stop_reg     <= 1'b0;
      edit_reg     <= 1'b0;
      field_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      btn_q_reg    <= btn;
      e_reg        <= e_next;
      ash_reg      <= ash_next;
      hin_reg      <= hin_next;
      tgt_reg      <= tgt_next;
      al_on_reg    <= al_on_next;
      hold_reg     <= hold_next;
      to_reg       <= to_next;
      ld_time_reg  <= ld_time_next;
      ld_alarm_reg <= ld_alarm_next;
      stop_reg     <= stop_next;
      edit_reg     <= edit_next;
      field_reg    <= field_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.H_in1    = hin_reg.h1;
  assign bus.H_in0    = hin_reg.h0;
  assign bus.M_in1    = hin_reg.m1;
  assign bus.M_in0    = hin_reg.m0;
  assign bus.LD_time  = ld_time_reg;
  assign bus.LD_alarm = ld_alarm_reg;
  assign bus.STOP_al  = stop_reg;
  assign bus.AL_ON    = al_on_reg;
  assign bus.edit     = edit_reg;
  assign bus.field    = field_reg;
  assign bus.tgt      = tgt_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_aclock_ctrl.sv
// tb_aclock_ctrl: self-checking bench for aclock_ctrl. A table of button
// vectors walks the main user scenarios with explicit expected outputs, a few
// hand-written sequences cover timeout, held buttons and reset during a load,
// and a randomized phase is compared cycle by cycle against a reference model
// that works in plain minutes-of-day arithmetic.
module tb_aclock_ctrl;
  localparam int LD_HOLD    = 12;
  localparam int SNOOZE_MIN = 5;
  localparam int TIMEOUT    = 1000;
  localparam int NV         = 26;

  logic clk;
  logic reset;
  aclock_ctrl_if bus ();

  aclock_ctrl #(
    .LD_HOLD   (LD_HOLD),
    .SNOOZE_MIN(SNOOZE_MIN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cur_min = 0;

  // Reference model state (times as minutes of day).
  int m_mode;  // 0 idle, 1 editing hours, 2 editing minutes, 3 strobing
  int m_eh, m_em, m_ash, m_hin, m_rem, m_idle;
  bit m_tgt, m_alon, m_ldt, m_lda, m_stop;
  bit pv_mode, pv_inc, pv_ok, pv_snz;

  logic [13:0] act_hin;
  logic [7:0]  act_flags;
  assign act_hin   = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
  assign act_flags = {bus.LD_time, bus.LD_alarm, bus.STOP_al, bus.AL_ON,
                      bus.edit, bus.field, bus.tgt, bus.busy};

  typedef struct {
    logic [3:0]  btn;    // {snooze, ok, inc, mode}
    int          reps;
    logic [15:0] cur;    // BCD hhmm
    bit          alarm;
    logic [7:0]  flags;  // {LD_time, LD_alarm, STOP_al, AL_ON, edit, field, tgt, busy}
    logic [15:0] hin;    // BCD hhmm
    int          len;    // expected strobe length
  } vec_t;
  vec_t vecs [NV];

  function automatic logic [13:0] min2bcd(int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic int bcd2min(logic [15:0] b);
    return (int'(b[13:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit any_strobe();
    return bus.LD_time | bus.LD_alarm | bus.STOP_al;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cur(int t);
    logic [13:0] b;
    cur_min = t;
    b = min2bcd(t);
    bus.cur_h1 = b[13:12];
    bus.cur_h0 = b[11:8];
    bus.cur_m1 = b[7:4];
    bus.cur_m0 = b[3:0];
  endtask

  task automatic drive_btn(logic [3:0] mask);
    bus.btn_mode   = mask[0];
    bus.btn_inc    = mask[1];
    bus.btn_ok     = mask[2];
    bus.btn_snooze = mask[3];
  endtask

  task automatic start_strobe(int val, bit lt, bit la, bit st);
    m_mode = 3;
    m_rem  = LD_HOLD;
    m_hin  = val;
    m_ldt  = lt;
    m_lda  = la;
    m_stop = st;
  endtask

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit pm, pi, po, ps, any;
    int v;
    pm = bus.btn_mode && !pv_mode;
    pi = bus.btn_inc && !pv_inc;
    po = bus.btn_ok && !pv_ok;
    ps = bus.btn_snooze && !pv_snz;
    any = pm | pi | po | ps;
    pv_mode = bus.btn_mode;
    pv_inc  = bus.btn_inc;
    pv_ok   = bus.btn_ok;
    pv_snz  = bus.btn_snooze;
    if (reset) begin
      m_mode = 0; m_eh = 0; m_em = 0; m_ash = 0; m_hin = 0; m_rem = 0; m_idle = 0;
      m_tgt = 0; m_alon = 0; m_ldt = 0; m_lda = 0; m_stop = 0;
      pv_mode = 0; pv_inc = 0; pv_ok = 0; pv_snz = 0;
    end else if (m_mode == 0) begin
      if (po) begin
        if (bus.alarm_in) start_strobe(m_ash, 0, 1, 1);
        else m_alon = !m_alon;
      end else if (ps && bus.alarm_in) begin
        start_strobe((cur_min + SNOOZE_MIN) % 1440, 0, 1, 1);
      end else if (pm) begin
        m_tgt = 0; m_eh = cur_min / 60; m_em = cur_min % 60; m_mode = 1; m_idle = 0;
      end
    end else if (m_mode == 3) begin
      m_rem--;
      if (m_rem == 0) begin
        m_mode = 0; m_ldt = 0; m_lda = 0; m_stop = 0;
      end
    end else begin
      if (any) m_idle = 0;
      else m_idle++;
      if (pm) begin
        m_tgt = !m_tgt;
        v = m_tgt ? m_ash : cur_min;
        m_eh = v / 60; m_em = v % 60; m_mode = 1;
      end else if (po) begin
        if (m_mode == 1) m_mode = 2;
        else begin
          v = m_eh * 60 + m_em;
          if (m_tgt) m_ash = v;
          start_strobe(v, !m_tgt, m_tgt, 0);
        end
      end else if (pi) begin
        if (m_mode == 1) m_eh = (m_eh + 1) % 24;
        else m_em = (m_em + 1) % 60;
      end else if (m_idle == TIMEOUT) begin
        m_mode = 0;
      end
    end
  endtask

  task automatic tick();
    logic [7:0] ef;
    model_step();
    @(posedge clk);
    #1;
    ef = {m_ldt, m_lda, m_stop, m_alon, (m_mode == 1 || m_mode == 2),
          (m_mode == 2), m_tgt, (m_mode == 3)};
    chk("cycle", {act_hin, act_flags}, {min2bcd(m_hin), ef});
  endtask

  // Releases buttons and counts how many cycles a strobe stays high,
  // including the cycle already showing; always gives at least one low cycle.
  task automatic finish_strobe(string name, int exp_len);
    int n;
    drive_btn(4'h0);
    n = any_strobe() ? 1 : 0;
    for (int k = 0; k < 4 * LD_HOLD; k++) begin
      tick();
      if (any_strobe()) n++;
      else break;
    end
    chk(name, n, exp_len);
  endtask

  initial begin
    reset = 1'b1;
    drive_btn(4'h0);
    bus.alarm_in = 1'b0;
    set_cur(0);

    //               btn    reps cur       al  flags         hin       len
    vecs[0]  = '{4'h1, 1,  16'h0000, 0, 8'b0000_1000, 16'h0000, 0};
    vecs[1]  = '{4'h2, 14, 16'h0000, 0, 8'b0000_1000, 16'h0000, 0};
    vecs[2]  = '{4'h4, 1,  16'h0000, 0, 8'b0000_1100, 16'h0000, 0};
    vecs[3]  = '{4'h2, 30, 16'h0000, 0, 8'b0000_1100, 16'h0000, 0};
    vecs[4]  = '{4'h4, 1,  16'h0000, 0, 8'b1000_0001, 16'h1430, 12};
    vecs[5]  = '{4'h1, 1,  16'h1430, 0, 8'b0000_1000, 16'h1430, 0};
    vecs[6]  = '{4'h1, 1,  16'h1430, 0, 8'b0000_1010, 16'h1430, 0};
    vecs[7]  = '{4'h2, 7,  16'h1430, 0, 8'b0000_1010, 16'h1430, 0};
    vecs[8]  = '{4'h4, 1,  16'h1430, 0, 8'b0000_1110, 16'h1430, 0};
    vecs[9]  = '{4'h2, 5,  16'h1430, 0, 8'b0000_1110, 16'h1430, 0};
    vecs[10] = '{4'h4, 1,  16'h1430, 0, 8'b0100_0011, 16'h0705, 12};
    vecs[11] = '{4'h4, 1,  16'h1430, 0, 8'b0001_0010, 16'h0705, 0};
    vecs[12] = '{4'h8, 1,  16'h2357, 1, 8'b0111_0011, 16'h0002, 12};
    vecs[13] = '{4'hC, 1,  16'h0705, 1, 8'b0111_0011, 16'h0705, 12};
    vecs[14] = '{4'h8, 1,  16'h1200, 0, 8'b0001_0010, 16'h0705, 0};
    vecs[15] = '{4'h9, 1,  16'h1058, 1, 8'b0111_0011, 16'h1103, 12};
    vecs[16] = '{4'h1, 1,  16'h2359, 0, 8'b0001_1000, 16'h1103, 0};
    vecs[17] = '{4'h2, 1,  16'h2359, 0, 8'b0001_1000, 16'h1103, 0};
    vecs[18] = '{4'h4, 1,  16'h2359, 0, 8'b0001_1100, 16'h1103, 0};
    vecs[19] = '{4'h2, 1,  16'h2359, 0, 8'b0001_1100, 16'h1103, 0};
    vecs[20] = '{4'h4, 1,  16'h2359, 0, 8'b1001_0001, 16'h0000, 12};
    vecs[21] = '{4'h1, 1,  16'h0930, 1, 8'b0001_1000, 16'h0000, 0};
    vecs[22] = '{4'h4, 1,  16'h0930, 1, 8'b0001_1100, 16'h0000, 0};
    vecs[23] = '{4'h1, 1,  16'h0930, 1, 8'b0001_1010, 16'h0000, 0};
    vecs[24] = '{4'h4, 1,  16'h0930, 1, 8'b0001_1110, 16'h0000, 0};
    vecs[25] = '{4'h4, 1,  16'h0930, 1, 8'b0101_0011, 16'h0705, 12};

    tick();
    tick();
    reset = 1'b0;
    chk("reset_hin", {18'd0, act_hin}, 32'd0);
    chk("reset_flags", {24'd0, act_flags}, 32'd0);
    $display("reset: hin=%h flags=%b", act_hin, act_flags);

    for (int i = 0; i < NV; i++) begin
      set_cur(bcd2min(vecs[i].cur));
      bus.alarm_in = vecs[i].alarm;
      for (int r = 0; r < vecs[i].reps; r++) begin
        if (r > 0) begin
          drive_btn(4'h0);
          tick();
        end
        drive_btn(vecs[i].btn);
        tick();
      end
      chk($sformatf("vec%0d_hin", i), {16'd0, 2'b00, act_hin}, {16'd0, vecs[i].hin});
      chk($sformatf("vec%0d_flags", i), {24'd0, act_flags}, {24'd0, vecs[i].flags});
      $display("vec %0d: btn=%h x%0d cur=%h alarm=%0d -> hin=%h flags=%b",
               i, vecs[i].btn, vecs[i].reps, vecs[i].cur, vecs[i].alarm, act_hin, act_flags);
      finish_strobe($sformatf("vec%0d_len", i), vecs[i].len);
    end

    // Held inc button: one increment only.
    bus.alarm_in = 1'b0;
    set_cur(8 * 60 + 15);
    drive_btn(4'h1); tick();
    drive_btn(4'h0); tick();
    drive_btn(4'h2);
    repeat (5) tick();
    drive_btn(4'h0); tick();
    drive_btn(4'h4); tick();
    drive_btn(4'h0); tick();
    drive_btn(4'h4); tick();
    chk("held_hin", {18'd0, act_hin}, 32'h0915);
    chk("held_ldtime", {31'd0, bus.LD_time}, 32'd1);
    $display("held inc: hin=%h LD_time=%0d", act_hin, bus.LD_time);
    finish_strobe("held_len", LD_HOLD);

    // Timeout in SET_MM.
    set_cur(60);
    drive_btn(4'h1); tick();
    drive_btn(4'h0); tick();
    drive_btn(4'h4); tick();
    drive_btn(4'h0);
    repeat (TIMEOUT - 1) tick();
    chk("timeout_still_edit", {31'd0, bus.edit}, 32'd1);
    tick();
    chk("timeout_idle", {27'd0, bus.LD_time, bus.LD_alarm, bus.STOP_al, bus.edit, bus.busy}, 32'd0);
    $display("timeout: edit=%0d busy=%0d", bus.edit, bus.busy);

    // Reset on the 5th cycle of a LOAD.
    set_cur(12 * 60 + 34);
    drive_btn(4'h1); tick();
    drive_btn(4'h0); tick();
    drive_btn(4'h4); tick();
    drive_btn(4'h0); tick();
    drive_btn(4'h4); tick();
    chk("midload_ldtime", {31'd0, bus.LD_time}, 32'd1);
    chk("midload_hin", {18'd0, act_hin}, 32'h1234);
    drive_btn(4'h0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midload_reset", {10'd0, act_hin, act_flags}, 32'd0);
    $display("reset in load: hin=%h flags=%b", act_hin, act_flags);
    tick();

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.btn_mode   = ($urandom_range(0, 5) == 0);
      bus.btn_inc    = ($urandom_range(0, 2) == 0);
      bus.btn_ok     = ($urandom_range(0, 5) == 0);
      bus.btn_snooze = ($urandom_range(0, 5) == 0);
      bus.alarm_in   = ($urandom_range(0, 2) == 0);
      set_cur(int'($urandom_range(0, 1439)));
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    $display("random phase: 3000 cycles, errors so far %0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
